// File: rtl/clint_bus_ctrl.sv
// clint_bus_ctrl: shares the single CLINT MMIO port between the core LSU
// (port 0) and the debug/host port (port 1). Round-robin grant, one
// outstanding transaction, fixed IDLE -> ACCESS -> RESP sequence, and an
// error response for misaligned accesses and writes to the reserved word.
module clint_bus_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                arst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_we,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_err,
    output logic                clint_write_en,
    output logic [1:0]          clint_addr,
    output logic [DATA_W-1:0]   clint_wdata,
    input  logic [DATA_W-1:0]   clint_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_last_grant;
    logic                r_owner;
    logic                r_we;
    logic                r_err;
    logic                r_clint_we;
    logic [1:0]          r_clint_addr;
    logic [DATA_W-1:0]   r_clint_wdata;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_err;

    logic                w_any_req;
    logic                w_accept;
    logic                w_sel_port;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_sel_err;

    // Pick the port to grant: a lone requester wins, on contention the port
    // that was not served last wins. Also decodes the selected request.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_any_req   = |req_valid;
        w_sel_port  = 1'b0;
        if (req_valid == 2'b11) begin
            w_sel_port = ~r_last_grant;
        end else begin
            w_sel_port = req_valid[1];
        end
        w_accept    = (r_state == IDLE) && w_any_req;
        w_sel_we    = w_sel_port ? req_we[1] : req_we[0];
        w_sel_addr  = w_sel_port ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        w_sel_wdata = w_sel_port ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
        // Misaligned accesses fail; word 3 is reserved and read-only.
        w_sel_err   = (w_sel_addr[1:0] != 2'b00) ||
                      (w_sel_we && (w_sel_addr[3:2] == 2'd3));
    end

    // Request accept is combinational so the handshake completes in the
    // same IDLE cycle the grant is made.
    always_comb begin
        req_ready = 2'b00;
        if (w_accept) begin
            req_ready[w_sel_port] = 1'b1;
        end
    end

    // Response valid follows the RESP state, only on the owning port.
    always_comb begin
        rsp_valid = 2'b00;
        if (r_state == RESP) begin
            rsp_valid[r_owner] = 1'b1;
        end
    end

    // Transaction sequencer: latch the granted request, run one CLINT
    // access cycle, then hold the response until the owner takes it.
    always_ff @(posedge clk) begin
        // NOTE: all state updates in clocked blocks use non-blocking
        // assignments so every register samples pre-edge values.
        if (arst) begin
            r_state       <= IDLE;
            r_last_grant  <= 1'b1;
            r_owner       <= 1'b0;
            r_we          <= 1'b0;
            r_err         <= 1'b0;
            r_clint_we    <= 1'b0;
            r_clint_addr  <= 2'd0;
            r_clint_wdata <= '0;
            r_rsp_data    <= '0;
            r_rsp_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_owner       <= w_sel_port;
                        r_last_grant  <= w_sel_port;
                        r_we          <= w_sel_we;
                        r_err         <= w_sel_err;
                        r_clint_addr  <= w_sel_addr[3:2];
                        r_clint_wdata <= w_sel_wdata;
                        r_clint_we    <= w_sel_we && !w_sel_err;
                        r_state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_clint_we <= 1'b0;
                    r_rsp_data <= (r_we || r_err) ? '0 : clint_rdata;
                    r_rsp_err  <= r_err;
                    r_state    <= RESP;
                end
                RESP: begin
                    if (rsp_ready[r_owner]) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // NOTE: the write strobe is masked by reset so a transaction abandoned
    // during its ACCESS cycle never commits its write at that edge.
    assign clint_write_en = r_clint_we && !arst;
    assign clint_addr     = r_clint_addr;
    assign clint_wdata    = r_clint_wdata;
    assign rsp_data       = r_rsp_data;
    assign rsp_err        = r_rsp_err;

endmodule

// File: tb/tb_clint_bus_ctrl.sv
// Directed testbench for clint_bus_ctrl with a small CLINT register model
// (MSIP, free-running MTIME, MTIMECMP, constant reserved word).
module tb_clint_bus_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam logic [31:0] RSVD_WORD = 32'hC0DE_0003;

    logic                clk = 1'b0;
    logic                arst;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_we;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [DATA_W-1:0]   rsp_data;
    logic                rsp_err;
    logic                clint_write_en;
    logic [1:0]          clint_addr;
    logic [DATA_W-1:0]   clint_wdata;
    logic [DATA_W-1:0]   clint_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_count = 0;

    logic [31:0] m_msip     = 32'd0;
    logic [31:0] m_mtime    = 32'd0;
    logic [31:0] m_mtimecmp = 32'd0;

    always #5 clk = ~clk;

    clint_bus_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .arst           (arst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_err        (rsp_err),
        .clint_write_en (clint_write_en),
        .clint_addr     (clint_addr),
        .clint_wdata    (clint_wdata),
        .clint_rdata    (clint_rdata)
    );

    // CLINT register model: MTIME ticks every cycle unless written.
    always @(posedge clk) begin
        m_mtime <= m_mtime + 32'd1;
        if (clint_write_en) begin
            case (clint_addr)
                2'd0: m_msip     <= clint_wdata;
                2'd1: m_mtime    <= clint_wdata;
                2'd2: m_mtimecmp <= clint_wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        clint_rdata = RSVD_WORD;
        case (clint_addr)
            2'd0: clint_rdata = m_msip;
            2'd1: clint_rdata = m_mtime;
            2'd2: clint_rdata = m_mtimecmp;
            default: clint_rdata = RSVD_WORD;
        endcase
    end

    always @(negedge clk) begin
        if (clint_write_en) wr_count++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Full transaction on port p with rsp_ready already high; called and
    // returns at posedge+1.
    task automatic txn(input int p, input logic we, input logic [3:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
        bit ok;
        rd = '0;
        er = 1'b0;
        req_we[p]             = we;
        req_addr[p*4 +: 4]    = addr;
        req_wdata[p*32 +: 32] = wd;
        req_valid[p]          = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[p]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("grant_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid[p]) begin
                ok = 1'b1;
                rd = rsp_data;
                er = rsp_err;
                break;
            end
        end
        if (!ok) check("rsp_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, req_ready, 2'b00);
        check({tag, "_rsp_valid"}, rsp_valid, 2'b00);
        check({tag, "_rsp_data"}, rsp_data, 32'd0);
        check({tag, "_rsp_err"}, rsp_err, 1'b0);
        check({tag, "_write_en"}, clint_write_en, 1'b0);
        check({tag, "_clint_addr"}, clint_addr, 2'd0);
        check({tag, "_clint_wdata"}, clint_wdata, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [31:0] d;
        logic        e;
        logic [31:0] exp_mtime;
        logic [1:0]  grants [$];
        int          w0;

        arst      = 1'b1;
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 2'b11;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        arst = 1'b0;

        // Contention right after reset: grants alternate starting at port 0.
        req_we    = 2'b00;
        req_addr  = 8'h00;
        req_valid = 2'b11;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) grants.push_back(req_ready);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        check("rr_count", grants.size(), 4);
        if (grants.size() == 4) begin
            check("rr_g0", grants[0], 2'b01);
            check("rr_g1", grants[1], 2'b10);
            check("rr_g2", grants[2], 2'b01);
            check("rr_g3", grants[3], 2'b10);
        end
        @(posedge clk); #1;

        // Port 0 writes 5 to MTIMECMP, cycle by cycle.
        req_we[0]         = 1'b1;
        req_addr[3:0]     = 4'h8;
        req_wdata[31:0]   = 32'd5;
        req_valid[0]      = 1'b1;
        @(negedge clk);
        check("w_ready", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("w_we_access", clint_write_en, 1'b1);
        check("w_addr", clint_addr, 2'd2);
        check("w_wdata", clint_wdata, 32'd5);
        check("w_rsp_early", rsp_valid, 2'b00);
        @(negedge clk);
        check("w_rsp_valid", rsp_valid, 2'b01);
        check("w_rsp_err", rsp_err, 1'b0);
        check("w_rsp_data", rsp_data, 32'd0);
        check("w_we_resp", clint_write_en, 1'b0);
        @(posedge clk); #1;
        check("w_mtimecmp", m_mtimecmp, 32'd5);

        // Error cases on port 1; reserved word is still readable.
        w0 = wr_count;
        txn(1, 1'b1, 4'h2, 32'h1234, d, e);
        check("mis_err", e, 1'b1);
        check("mis_data", d, 32'd0);
        txn(1, 1'b1, 4'hC, 32'h5678, d, e);
        check("rsv_w_err", e, 1'b1);
        check("rsv_w_data", d, 32'd0);
        check("err_no_write", wr_count, w0);
        txn(1, 1'b0, 4'hC, 32'd0, d, e);
        check("rsv_r_err", e, 1'b0);
        check("rsv_r_data", d, RSVD_WORD);

        // MTIME read stalled in RESP; port 1 requests meanwhile.
        rsp_ready     = 2'b00;
        req_we[0]     = 1'b0;
        req_addr[3:0] = 4'h4;
        req_valid[0]  = 1'b1;
        @(negedge clk);
        check("mt_ready", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid[0]  = 1'b0;
        req_we[1]     = 1'b0;
        req_addr[7:4] = 4'h0;
        req_valid[1]  = 1'b1;
        @(negedge clk);
        exp_mtime = m_mtime;
        check("mt_addr", clint_addr, 2'd1);
        check("mt_no_ready_access", req_ready, 2'b00);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("mt_valid_held", rsp_valid, 2'b01);
            check("mt_data_held", rsp_data, exp_mtime);
            check("mt_p1_blocked", req_ready, 2'b00);
        end
        rsp_ready = 2'b11;
        @(negedge clk);
        check("mt_p1_granted", req_ready, 2'b10);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Write MSIP then read it back.
        txn(0, 1'b1, 4'h0, 32'd1, d, e);
        check("msip_w_err", e, 1'b0);
        txn(0, 1'b0, 4'h0, 32'hABCD, d, e);
        check("msip_r_data", d, 32'd1);
        check("msip_r_err", e, 1'b0);

        // Reset during ACCESS: write must not happen.
        w0            = wr_count;
        req_we[0]     = 1'b1;
        req_addr[3:0] = 4'h8;
        req_wdata[31:0] = 32'h77;
        req_valid[0]  = 1'b1;
        @(negedge clk);
        check("ra_ready", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        arst = 1'b1;
        @(negedge clk);
        check("ra_no_we", clint_write_en, 1'b0);
        @(posedge clk); #1;
        arst = 1'b0;
        @(negedge clk);
        check_all_zero("ra_after");
        check("ra_mtimecmp", m_mtimecmp, 32'd5);
        check("ra_no_write", wr_count, w0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("ra_no_rsp", rsp_valid, 2'b00);
        end
        @(posedge clk); #1;

        // Reset during RESP: response is dropped.
        rsp_ready     = 2'b00;
        req_we[0]     = 1'b0;
        req_addr[3:0] = 4'h0;
        req_valid[0]  = 1'b1;
        @(negedge clk);
        check("rr_ready", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rr_valid", rsp_valid, 2'b01);
        check("rr_data", rsp_data, 32'd1);
        @(posedge clk); #1;
        arst = 1'b1;
        @(posedge clk); #1;
        arst = 1'b0;
        @(negedge clk);
        check_all_zero("rr_after");
        rsp_ready = 2'b11;

        // Contention after reset: port 0 wins despite port 0 being served last.
        @(posedge clk); #1;
        req_we    = 2'b00;
        req_addr  = 8'h00;
        req_valid = 2'b11;
        @(negedge clk);
        check("post_rst_grant", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (4) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
